// File: rtl/add_operand_feeder.sv
// Operand FIFO feeding an external combinational adder; the adder's sum is
// captured together with its operands into a single result register.
module add_operand_feeder #(
    parameter int W     = 4,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         sync_clr,
    output logic [W-1:0] add_a,
    output logic [W-1:0] add_b,
    input  logic [W-1:0] add_sum,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_a,
    output logic [W-1:0] res_b,
    output logic [W-1:0] res_sum,
    output logic         res_wrap,
    output logic         busy,
    output logic [7:0]   res_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_a_q [DEPTH];
    logic [W-1:0]  mem_a_d [DEPTH];
    logic [W-1:0]  mem_b_q [DEPTH];
    logic [W-1:0]  mem_b_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          res_valid_q, res_valid_d;
    logic [W-1:0]  res_a_q, res_a_d, res_b_q, res_b_d, res_sum_q, res_sum_d;
    logic          res_wrap_q, res_wrap_d;
    logic [7:0]    res_count_q, res_count_d;

    logic          nempty, push, pop;
    logic [W-1:0]  head_a, head_b;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready depends on registered occupancy only, so a full FIFO stays
    // closed even in a cycle where the head is being popped.
    assign in_ready = (count_q < CW'(DEPTH));
    assign nempty   = (count_q != '0);
    assign push     = in_valid && in_ready;
    assign pop      = nempty && (!res_valid_q || res_ready);
    assign head_a   = mem_a_q[head_q];
    assign head_b   = mem_b_q[head_q];
    assign add_a    = nempty ? head_a : '0;
    assign add_b    = nempty ? head_b : '0;

    always_comb begin
        mem_a_d     = mem_a_q;
        mem_b_d     = mem_b_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        res_valid_d = res_valid_q;
        res_a_d     = res_a_q;
        res_b_d     = res_b_q;
        res_sum_d   = res_sum_q;
        res_wrap_d  = res_wrap_q;
        res_count_d = res_count_q;
        if (sync_clr) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            res_valid_d = 1'b0;
        end else begin
            if (push) begin
                mem_a_d[tail_q] = in_a;
                mem_b_d[tail_q] = in_b;
                tail_d          = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d      = ptr_inc(head_q);
                res_valid_d = 1'b1;
                res_a_d     = head_a;
                res_b_d     = head_b;
                res_sum_d   = add_sum;
                res_wrap_d  = (add_sum < head_a);
            end else if (res_valid_q && res_ready) begin
                res_valid_d = 1'b0;
            end
            if (push && !pop)
                count_d = count_q + 1'b1;
            else if (pop && !push)
                count_d = count_q - 1'b1;
            if (res_valid_q && res_ready)
                res_count_d = res_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_a_q     <= '0;
            res_b_q     <= '0;
            res_sum_q   <= '0;
            res_wrap_q  <= 1'b0;
            res_count_q <= '0;
        end else begin
            mem_a_q     <= mem_a_d;
            mem_b_q     <= mem_b_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_a_q     <= res_a_d;
            res_b_q     <= res_b_d;
            res_sum_q   <= res_sum_d;
            res_wrap_q  <= res_wrap_d;
            res_count_q <= res_count_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_a     = res_a_q;
    assign res_b     = res_b_q;
    assign res_sum   = res_sum_q;
    assign res_wrap  = res_wrap_q;
    assign res_count = res_count_q;
    assign busy      = nempty || res_valid_q;

endmodule

// File: tb/tb_add_operand_feeder.sv
// Directed bench for add_operand_feeder (W=4, DEPTH=2) with a behavioural
// adder closing the add_a/add_b -> add_sum loop.
module tb_add_operand_feeder;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_ready, sync_clr, res_valid, res_ready;
    logic       res_wrap, busy;
    logic [3:0] in_a, in_b, add_a, add_b, add_sum, res_a, res_b, res_sum;
    logic [7:0] res_count;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    add_operand_feeder #(.W(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .sync_clr(sync_clr), .add_a(add_a),
        .add_b(add_b), .add_sum(add_sum), .res_valid(res_valid),
        .res_ready(res_ready), .res_a(res_a), .res_b(res_b),
        .res_sum(res_sum), .res_wrap(res_wrap), .busy(busy),
        .res_count(res_count)
    );

    assign add_sum = add_a + add_b;

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        sync_clr = 1'b0; res_ready = 1'b0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (res_count !== 8'd0) begin n_err++; $display("FAIL reset_res_count got %0d want 0", res_count); end
        n_cmp++; if (add_a !== 4'd0) begin n_err++; $display("FAIL reset_add_a got %0d want 0", add_a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_a = 4'd5; in_b = 4'd5; res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (add_a !== 4'd5 || add_b !== 4'd5) begin n_err++; $display("FAIL single_head got %0d,%0d want 5,5", add_a, add_b); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid got %b want 0", res_valid); end
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL single_valid got %b want 1", res_valid); end
        n_cmp++; if (res_sum !== 4'd10) begin n_err++; $display("FAIL single_sum got %0d want 10", res_sum); end
        n_cmp++; if (res_wrap !== 1'b0) begin n_err++; $display("FAIL single_wrap got %b want 0", res_wrap); end
        exp_cnt++;
        @(posedge clk); #1;
        n_cmp++; if (res_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL single_count got %0d want %0d", res_count, exp_cnt); end
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle got v=%b busy=%b want 0,0", res_valid, busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] sa [3] = '{4'd8, 4'd15, 4'd3};
        logic [3:0] sb [3] = '{4'd2, 4'd1, 4'd4};
        logic [3:0] es [3] = '{4'd10, 4'd0, 4'd7};
        logic       ew [3] = '{1'b0, 1'b1, 1'b0};
        res_ready = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            if (n < 3) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %b want 1", n, in_ready); end
                in_valid = 1'b1; in_a = sa[n]; in_b = sb[n];
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (n >= 1) begin
                n_cmp++;
                if (res_valid !== 1'b1 || res_sum !== es[n-1] || res_wrap !== ew[n-1]) begin
                    n_err++;
                    $display("FAIL stream_res[%0d] got v=%b sum=%0d wrap=%b want v=1 sum=%0d wrap=%b",
                             n - 1, res_valid, res_sum, res_wrap, es[n-1], ew[n-1]);
                end
                exp_cnt++;
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL stream_tail_valid got %b want 0", res_valid); end
        n_cmp++; if (res_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL stream_count got %0d want %0d", res_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'(2 * i + 1); in_b = 4'(2 * i + 2);
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (acc !== 3) begin n_err++; $display("FAIL bp_accepted got %0d want 3", acc); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        n_cmp++; if (res_valid !== 1'b1 || res_sum !== 4'd3) begin n_err++; $display("FAIL bp_first got v=%b sum=%0d want 1,3", res_valid, res_sum); end
        @(posedge clk); #1;
        n_cmp++; if (res_a !== 4'd1 || res_b !== 4'd2 || res_sum !== 4'd3) begin n_err++; $display("FAIL bp_hold got %0d,%0d,%0d want 1,2,3", res_a, res_b, res_sum); end
        res_ready = 1'b1;
        @(posedge clk); #1; exp_cnt++;
        n_cmp++; if (res_sum !== 4'd7 || res_a !== 4'd3) begin n_err++; $display("FAIL bp_second got a=%0d sum=%0d want 3,7", res_a, res_sum); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_reopen got %b want 1", in_ready); end
        @(posedge clk); #1; exp_cnt++;
        n_cmp++; if (res_sum !== 4'd11 || res_valid !== 1'b1) begin n_err++; $display("FAIL bp_third got v=%b sum=%0d want 1,11", res_valid, res_sum); end
        @(posedge clk); #1; exp_cnt++;
        n_cmp++; if (res_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_drained got v=%b busy=%b want 0,0", res_valid, busy); end
        n_cmp++; if (res_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL bp_count got %0d want %0d", res_count, exp_cnt); end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        res_ready = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (res_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL flush_pre got v=%b rdy=%b want 1,0", res_valid, in_ready); end
        sync_clr = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        n_cmp++; if (busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL flush_clear got busy=%b v=%b want 0,0", busy, res_valid); end
        n_cmp++; if (in_ready !== 1'b1 || add_a !== 4'd0) begin n_err++; $display("FAIL flush_fifo got rdy=%b add_a=%0d want 1,0", in_ready, add_a); end
        n_cmp++; if (res_count !== 8'(exp_cnt)) begin n_err++; $display("FAIL flush_count got %0d want %0d", res_count, exp_cnt); end
        res_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (res_valid) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_ghost got %b want 0", seen); end
    endtask

    task automatic test_async_reset();
        res_ready = 1'b0;
        for (int i = 4; i <= 6; i++) begin
            in_valid = 1'b1; in_a = 4'(i); in_b = 4'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL arst_full got %b want 0", in_ready); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin n_err++; $display("FAIL arst_ctrl got rdy=%b busy=%b v=%b want 1,0,0", in_ready, busy, res_valid); end
        n_cmp++; if (res_a !== 4'd0 || res_b !== 4'd0 || res_sum !== 4'd0 || res_wrap !== 1'b0) begin n_err++; $display("FAIL arst_data got %0d,%0d,%0d,%b want 0,0,0,0", res_a, res_b, res_sum, res_wrap); end
        n_cmp++; if (res_count !== 8'd0 || add_a !== 4'd0) begin n_err++; $display("FAIL arst_count got cnt=%0d add_a=%0d want 0,0", res_count, add_a); end
        exp_cnt = 0;
        rst_n = 1'b1;
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; res_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++; if (add_a !== 4'd9 || res_valid !== 1'b0) begin n_err++; $display("FAIL arst_first_accept got add_a=%0d v=%b want 9,0", add_a, res_valid); end
        @(posedge clk); #1;
        n_cmp++; if (res_valid !== 1'b1 || res_sum !== 4'd2 || res_wrap !== 1'b1 || res_a !== 4'd9) begin n_err++; $display("FAIL arst_first_res got v=%b sum=%0d wrap=%b a=%0d want 1,2,1,9", res_valid, res_sum, res_wrap, res_a); end
        exp_cnt++;
        @(posedge clk); #1;
        n_cmp++; if (res_count !== 8'(exp_cnt) || busy !== 1'b0) begin n_err++; $display("FAIL arst_after got cnt=%0d busy=%b want %0d,0", res_count, busy, exp_cnt); end
    endtask

    task automatic test_pointer_wrap();
        logic [3:0] ea, eb;
        res_ready = 1'b1;
        for (int n = 0; n <= 20; n++) begin
            if (n < 20) begin
                in_valid = 1'b1; in_a = 4'(3 * n + 1); in_b = 4'(5 * n + 2);
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (n >= 1) begin
                ea = 4'(3 * (n - 1) + 1);
                eb = 4'(5 * (n - 1) + 2);
                n_cmp++;
                if (res_valid !== 1'b1 || res_a !== ea || res_sum !== 4'((ea + eb) % 16)) begin
                    n_err++;
                    $display("FAIL wrap_res[%0d] got v=%b a=%0d sum=%0d want 1,%0d,%0d",
                             n - 1, res_valid, res_a, res_sum, ea, (ea + eb) % 16);
                end
                exp_cnt++;
            end
        end
        @(posedge clk); #1;
        n_cmp++; if (res_count !== 8'(exp_cnt) || busy !== 1'b0) begin n_err++; $display("FAIL wrap_count got cnt=%0d busy=%b want %0d,0", res_count, busy, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_pointer_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/add_operand_feeder.md
ADD_OPERAND_FEEDER -- requirements
Module: add_operand_feeder

Interface
REQ-001 Parameter: W, 4, operand and sum width in bits.
REQ-002 Parameter: DEPTH, 2, operand FIFO depth in entries, 2 to 16.
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  operand pair offered.
REQ-006 Port: in_ready  output  1  operand pair will be accepted this cycle.
REQ-007 Port: in_a  input  W  operand A.
REQ-008 Port: in_b  input  W  operand B.
REQ-009 Port: sync_clr  input  1  synchronous flush of all queued work.
REQ-010 Port: add_a  output  W  drives the downstream adder input A.
REQ-011 Port: add_b  output  W  drives the downstream adder input B.
REQ-012 Port: add_sum  input  W  combinational Sum returned by the adder.
REQ-013 Port: res_valid  output  1  result register holds a valid result.
REQ-014 Port: res_ready  input  1  consumer accepts the result.
REQ-015 Port: res_a, res_b, res_sum  output  W each  operands and captured sum.
REQ-016 Port: res_wrap  output  1  the unsigned sum wrapped modulo 2^W.
REQ-017 Port: busy  output  1  FIFO non-empty or res_valid high.
REQ-018 Port: res_count  output  8  number of results delivered, wrapping.

Function
REQ-019 Accept: an operand pair is written at the tail on a clock edge where in_valid and in_ready are both high.
REQ-020 in_ready: in_ready SHALL equal (fifo_count < DEPTH), registered-state only, with no combinational path from res_ready.
REQ-021 Full FIFO: when the FIFO is full, in_ready SHALL be low even if a pop occurs in the same cycle.
REQ-022 Adder drive: add_a and add_b SHALL present the head entry while the FIFO is non-empty, and SHALL be 0 when it is empty.
REQ-023 Issue: the head SHALL be popped when the FIFO is non-empty and (res_valid is low or res_ready is high). On that edge, head A, head B and add_sum are loaded into res_a, res_b and res_sum, and res_valid is set.
REQ-024 Drain: res_valid SHALL clear on an edge where res_valid and res_ready are high and no issue occurs.
REQ-025 Wrap flag: res_wrap SHALL be loaded as (add_sum < head A), computed from the adder's own output.
REQ-026 Latency: a pair accepted on edge k SHALL appear with res_valid high after edge k+1 when the FIFO was empty and the result register is free.
REQ-027 Throughput: the block SHALL sustain one result per cycle while in_valid and res_ready stay high.
REQ-028 Simultaneous push and pop: fifo_count is unchanged, and head and tail pointers each advance modulo DEPTH.
REQ-029 Ordering: results SHALL leave in acceptance order, with no loss and no duplication.
REQ-030 Result hold: res_a, res_b, res_sum and res_wrap SHALL be stable while res_valid is high and res_ready is low.
REQ-031 Result counter: res_count SHALL increment by 1 on each res_valid and res_ready edge, wrapping from 255 to 0.
REQ-032 sync_clr: sync_clr SHALL take priority over push, pop and capture. On the next edge the FIFO empties, res_valid is cleared and pointers return to 0. res_count is held, and in_ready is high the following cycle.

Reset
REQ-033 While rst_n is low, the block SHALL be in its reset state immediately, independent of clk: fifo_count 0, pointers 0, res_valid 0, res_a, res_b, res_sum and res_wrap 0, res_count 0, busy 0, in_ready 1.
REQ-034 A reset asserted mid-operation SHALL discard all queued and captured pairs, and no result is produced for them after release.
REQ-035 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-036 Single pair: push A=5, B=5 with res_ready high -> one cycle later res_valid=1, res_sum=10, res_wrap=0, res_count=1.
REQ-037 Stream: push (8,2), (15,1), (3,4) back-to-back with res_ready high -> results in order: sum 10 wrap 0, then 0 wrap 1, then 7 wrap 0, one per cycle.
REQ-038 Backpressure: res_ready low, push 4 pairs -> 3 accepted (2 in FIFO, 1 in result register), in_ready low. Raising res_ready drains all 3 in order and in_ready returns high.
REQ-039 Flush: with 2 pairs queued and res_valid high, pulse sync_clr -> busy=0 and res_valid=0 next cycle, and no further results appear.
REQ-040 Async reset: assert rst_n low between edges with a full FIFO -> all outputs reach their reset values without a clock edge, and res_count=0.
REQ-041 Pointer wrap: push and pop 20 pairs continuously -> every result's res_sum equals (A+B) mod 16, in acceptance order.
